// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C register-write master
package i2c_pkg;

    // Transaction phases, in bus order
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_DEV,
        ST_DEV_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_DAT,
        ST_DAT_ACK,
        ST_STOP
    } state_e;

    // Position and meaning of the R/W flag inside the device byte
    localparam int   RW_BIT  = 0;
    localparam logic RW_READ = 1'b1;

    // SDA level driven by the slave in the acknowledge slot
    localparam logic ACK_LEVEL  = 1'b0;
    localparam logic NACK_LEVEL = 1'b1;

    // Bits per byte and the matching down-counter geometry
    localparam int          BYTE_BITS = 8;
    localparam int          BIT_W     = $clog2(BYTE_BITS);
    localparam logic [BIT_W-1:0] BIT_MSB = BIT_W'(BYTE_BITS - 1);

endpackage

// File: rtl/i2c_tick_gen.sv
// rtl/i2c_tick_gen.sv - SCL half-period divider with tick and high-half midpoint strobe
//
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset
//   en_i    count enable; the counter is held at zero while low
//   tick_o  one-cycle pulse ending each HALF_DIV-cycle half period
//   mid_o   one-cycle pulse HALF_DIV/2 cycles into each half period
module i2c_tick_gen #(
    parameter int HALF_DIV = 12
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o,
    output logic mid_o
);

    localparam int CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF_DIV / 2 - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == CNT_LAST);
    assign mid_o  = en_i && (cnt_q == CNT_MID);

endmodule

// File: rtl/i2c_write_master.sv
// rtl/i2c_write_master.sv - serialises one register write as START/dev/reg/data/STOP on SCL/SDA
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   en_write                 request strobe, honoured only while idle
//   cs_addr[7:0]             device address [7:1] and R/W flag [0]
//   rw_addr[7:0]             register address byte
//   input_data[7:0]          data byte
//   sda_in                   sampled SDA line, read in acknowledge slots
//   scl                      SCL level (1 = released)
//   sda_oe                   1 = pull SDA low
//   busy                     transaction in progress
//   done                     one-cycle completion / rejection pulse
//   ack_err                  sticky NACK or rejected-read flag
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int HALF_DIV = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_write,
    input  logic [7:0] cs_addr,
    input  logic [7:0] rw_addr,
    input  logic [7:0] input_data,
    input  logic       sda_in,
    output logic       scl,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    state_e           state_q, state_d;
    logic             ph_q, ph_d;          // 0 = SCL low half, 1 = SCL high half
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic [7:0]       reg_q, reg_d;
    logic [7:0]       dat_q, dat_d;
    logic             nack_q, nack_d;
    logic             scl_q, scl_d;
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;

    logic             req_idle;
    logic             accept_write;
    logic             tick;
    logic             mid;

    assign req_idle     = (state_q == ST_IDLE) && en_write;
    assign accept_write = req_idle && (cs_addr[RW_BIT] != RW_READ);

    // The divider also runs in the accept cycle so that cycle counts as the
    // first clock of the START half period.
    i2c_tick_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_tick_gen (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (busy_q | accept_write),
        .tick_o (tick),
        .mid_o  (mid)
    );

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        reg_d     = reg_q;
        dat_d     = dat_q;
        nack_d    = nack_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_idle) begin
                    if (cs_addr[RW_BIT] == RW_READ) begin
                        done_d    = 1'b1;
                        ack_err_d = 1'b1;
                    end else begin
                        state_d   = ST_START;
                        ph_d      = 1'b0;
                        bit_d     = BIT_MSB;
                        sh_d      = cs_addr;
                        reg_d     = rw_addr;
                        dat_d     = input_data;
                        nack_d    = 1'b0;
                        busy_d    = 1'b1;
                        ack_err_d = 1'b0;
                    end
                end
            end

            ST_START: begin
                if (tick) begin
                    if (!ph_q) begin
                        ph_d = 1'b1;
                    end else begin
                        ph_d    = 1'b0;
                        state_d = ST_DEV;
                    end
                end
            end

            ST_DEV, ST_REG, ST_DAT: begin
                if (tick) begin
                    if (!ph_q) begin
                        ph_d = 1'b1;
                    end else begin
                        ph_d  = 1'b0;
                        sh_d  = {sh_q[6:0], 1'b0};
                        bit_d = bit_q - 1'b1;
                        if (bit_q == '0) begin
                            case (state_q)
                                ST_DEV:  state_d = ST_DEV_ACK;
                                ST_REG:  state_d = ST_REG_ACK;
                                default: state_d = ST_DAT_ACK;
                            endcase
                        end
                    end
                end
            end

            ST_DEV_ACK, ST_REG_ACK, ST_DAT_ACK: begin
                // mid and tick never coincide, so the sample is settled in
                // nack_q by the time the slot ends.
                if (mid && ph_q && (sda_in == NACK_LEVEL)) begin
                    nack_d = 1'b1;
                end
                if (tick) begin
                    if (!ph_q) begin
                        ph_d = 1'b1;
                    end else begin
                        ph_d   = 1'b0;
                        nack_d = 1'b0;
                        bit_d  = BIT_MSB;
                        if (nack_q) begin
                            state_d   = ST_STOP;
                            ack_err_d = 1'b1;
                        end else if (state_q == ST_DEV_ACK) begin
                            state_d = ST_REG;
                            sh_d    = reg_q;
                        end else if (state_q == ST_REG_ACK) begin
                            state_d = ST_DAT;
                            sh_d    = dat_q;
                        end else begin
                            state_d = ST_STOP;
                        end
                    end
                end
            end

            ST_STOP: begin
                if (tick) begin
                    if (!ph_q) begin
                        ph_d = 1'b1;
                    end else begin
                        ph_d    = 1'b0;
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Bus levels follow the next phase so they change on the same edge as
        // the state; data bits only change together with SCL falling.
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        case (state_d)
            ST_START: begin
                scl_d    = ~ph_d;
                sda_oe_d = 1'b1;
            end
            ST_DEV, ST_REG, ST_DAT: begin
                scl_d    = ph_d;
                sda_oe_d = ~sh_d[7];
            end
            ST_DEV_ACK, ST_REG_ACK, ST_DAT_ACK: begin
                scl_d    = ph_d;
                sda_oe_d = 1'b0;
            end
            ST_STOP: begin
                // SDA held low through the high half; the release on return
                // to idle forms the STOP condition.
                scl_d    = ph_d;
                sda_oe_d = 1'b1;
            end
            default: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ph_q      <= 1'b0;
            bit_q     <= '0;
            sh_q      <= '0;
            reg_q     <= '0;
            dat_q     <= '0;
            nack_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            reg_q     <= reg_d;
            dat_q     <= dat_d;
            nack_q    <= nack_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign scl     = scl_q;
    assign sda_oe  = sda_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_write_master.sv
// tb/tb_i2c_write_master.sv - self-checking bench for i2c_write_master
module tb_i2c_write_master;

    localparam int HALF_DIV = 12;
    localparam int NO_NACK  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_write = 1'b0;
    logic [7:0] cs_addr = 8'h00;
    logic [7:0] rw_addr = 8'h00;
    logic [7:0] input_data = 8'h00;
    logic       sda_in;
    logic       scl, sda_oe, busy, done, ack_err;

    int n_chk  = 0;
    int n_fail = 0;

    // Bus / slave model state (written only by the monitor process)
    logic       slave_pull = 1'b0;
    logic       scl_p = 1'b1, sda_p = 1'b1, cur_bit = 1'b0;
    logic       in_frame = 1'b0, have_bit = 1'b0;
    logic [7:0] shv = 8'h00;
    int         bitn = 0, byte_idx = 0;
    int         starts = 0, stops = 0, viol = 0, scl_toggles = 0;
    logic [7:0] got[$];

    // Written only by the stimulus process
    int         slave_nack_at = NO_NACK;
    logic       mon_off = 1'b0;
    int         exp_starts = 0, exp_stops = 0;

    logic       sda_w;
    assign sda_w  = (sda_oe || slave_pull) ? 1'b0 : 1'b1;
    assign sda_in = sda_w;

    always #5 clk = ~clk;

    i2c_write_master #(.HALF_DIV(HALF_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .en_write   (en_write),
        .cs_addr    (cs_addr),
        .rw_addr    (rw_addr),
        .input_data (input_data),
        .sda_in     (sda_in),
        .scl        (scl),
        .sda_oe     (sda_oe),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err)
    );

    // Bus monitor and ACKing slave, sampled on the falling clock edge
    always @(negedge clk) begin
        if (mon_off || rst) begin
            in_frame = 1'b0; have_bit = 1'b0; bitn = 0; slave_pull = 1'b0;
        end else begin
            if (scl != scl_p) scl_toggles++;
            if (scl && scl_p && (sda_w != sda_p)) begin
                if (!sda_w) begin
                    if (in_frame) viol++;
                    starts++; in_frame = 1'b1; have_bit = 1'b0; bitn = 0; byte_idx = 0;
                end else begin
                    if (!in_frame || bitn != 0) viol++;
                    stops++; in_frame = 1'b0; have_bit = 1'b0;
                end
            end else if (scl && !scl_p) begin
                cur_bit = sda_w; have_bit = 1'b1;
            end else if (!scl && scl_p && have_bit) begin
                have_bit = 1'b0;
                if (bitn < 8) begin
                    shv = {shv[6:0], cur_bit};
                    bitn++;
                    if (bitn == 8) begin
                        got.push_back(shv);
                        slave_pull = (byte_idx != slave_nack_at);
                    end
                end else begin
                    bitn = 0; byte_idx++; slave_pull = 1'b0;
                end
            end
        end
        scl_p = scl;
        sda_p = sda_w;
    end

    // Reference model: bytes reaching the bus, accept-to-done cycles, error flag
    function automatic int model_nbytes(input logic [7:0] cs, input int nack_at);
        if (cs[0]) return 0;
        return (nack_at < 3) ? nack_at + 1 : 3;
    endfunction

    function automatic int model_lat(input logic [7:0] cs, input int nack_at);
        if (cs[0]) return 1;
        // START slot + 9 slots per byte sent + STOP slot, two half periods each
        return (2 + 9 * model_nbytes(cs, nack_at)) * 2 * HALF_DIV;
    endfunction

    function automatic logic model_err(input logic [7:0] cs, input int nack_at);
        return cs[0] || (nack_at < 3);
    endfunction

    // Issue one request (called at a falling edge); lat = cycles from the
    // en_write cycle to the first cycle with done high.
    task automatic do_req(input logic [7:0] cs, input logic [7:0] rw, input logic [7:0] dat,
                          input int nack_at, output int lat, output logic busy1, output logic err1);
        slave_nack_at = nack_at;
        cs_addr = cs; rw_addr = rw; input_data = dat;
        en_write = 1'b1;
        @(negedge clk);
        en_write = 1'b0;
        lat = 1; busy1 = busy; err1 = ack_err;
        while (!done && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (scl !== 1'b1)     begin n_fail++; $display("FAIL reset_scl got=%b exp=1", scl); end
        n_chk++; if (sda_oe !== 1'b0)  begin n_fail++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
        n_chk++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_chk++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_chk++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err got=%b exp=0", ack_err); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_write();
        logic [7:0] eb[3];
        int lat, base;
        logic b1, e1;
        eb = '{8'h0E, 8'h48, 8'h55};
        base = got.size();
        do_req(8'h0E, 8'h48, 8'h55, NO_NACK, lat, b1, e1);
        exp_starts++; exp_stops++;
        n_chk++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL basic_busy got=%b exp=1", b1); end
        n_chk++; if (lat != model_lat(8'h0E, NO_NACK)) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", lat, model_lat(8'h0E, NO_NACK)); end
        n_chk++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL basic_ack_err got=%b exp=0", ack_err); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
        n_chk++; if (got.size() - base != 3) begin n_fail++; $display("FAIL basic_nbytes got=%0d exp=3", got.size() - base); end
        for (int i = 0; i < 3 && base + i < got.size(); i++) begin
            n_chk++; if (got[base + i] !== eb[i]) begin n_fail++; $display("FAIL basic_byte%0d got=%h exp=%h", i, got[base + i], eb[i]); end
        end
        @(negedge clk);
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_nack_dev();
        int lat, base;
        logic b1, e1;
        base = got.size();
        do_req(8'h0E, 8'h48, 8'h55, 0, lat, b1, e1);
        exp_starts++; exp_stops++;
        n_chk++; if (lat != model_lat(8'h0E, 0)) begin n_fail++; $display("FAIL nack_latency got=%0d exp=%0d", lat, model_lat(8'h0E, 0)); end
        n_chk++; if (ack_err !== 1'b1) begin n_fail++; $display("FAIL nack_ack_err got=%b exp=1", ack_err); end
        n_chk++; if (got.size() - base != 1) begin n_fail++; $display("FAIL nack_nbytes got=%0d exp=1", got.size() - base); end
        if (got.size() > base) begin
            n_chk++; if (got[base] !== 8'h0E) begin n_fail++; $display("FAIL nack_dev_byte got=%h exp=0e", got[base]); end
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_busy();
        logic [7:0] eb[3];
        int lat, base;
        logic b101;
        eb = '{8'h0E, 8'h49, 8'hAA};
        base = got.size();
        b101 = 1'b0;
        slave_nack_at = NO_NACK;
        cs_addr = 8'h0E; rw_addr = 8'h49; input_data = 8'hAA;
        en_write = 1'b1;
        @(negedge clk);
        en_write = 1'b0;
        lat = 1;
        while (!done && lat < 2000) begin
            if (lat == 100) begin
                rw_addr = 8'h4A; input_data = 8'hCC; en_write = 1'b1;
            end else begin
                en_write = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (lat == 101) b101 = busy;
        end
        en_write = 1'b0;
        exp_starts++; exp_stops++;
        n_chk++; if (b101 !== 1'b1) begin n_fail++; $display("FAIL ignore_busy got=%b exp=1", b101); end
        n_chk++; if (lat != model_lat(8'h0E, NO_NACK)) begin n_fail++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, model_lat(8'h0E, NO_NACK)); end
        repeat (20) @(negedge clk);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_queue got=%b exp=0", busy); end
        n_chk++; if (got.size() - base != 3) begin n_fail++; $display("FAIL ignore_nbytes got=%0d exp=3", got.size() - base); end
        for (int i = 0; i < 3 && base + i < got.size(); i++) begin
            n_chk++; if (got[base + i] !== eb[i]) begin n_fail++; $display("FAIL ignore_byte%0d got=%h exp=%h", i, got[base + i], eb[i]); end
        end
    endtask

    task automatic test_read_reject();
        int lat, tog0;
        logic b1, e1;
        tog0 = scl_toggles;
        do_req(8'h0F, 8'h48, 8'h55, NO_NACK, lat, b1, e1);
        n_chk++; if (lat != model_lat(8'h0F, NO_NACK)) begin n_fail++; $display("FAIL read_latency got=%0d exp=%0d", lat, model_lat(8'h0F, NO_NACK)); end
        n_chk++; if (ack_err !== 1'b1) begin n_fail++; $display("FAIL read_ack_err got=%b exp=1", ack_err); end
        n_chk++; if (b1 !== 1'b0) begin n_fail++; $display("FAIL read_busy got=%b exp=0", b1); end
        @(negedge clk);
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL read_done_pulse got=%b exp=0", done); end
        repeat (30) @(negedge clk);
        n_chk++; if (scl_toggles != tog0) begin n_fail++; $display("FAIL read_scl_activity got=%0d exp=%0d", scl_toggles, tog0); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] eb[3];
        int lat, base;
        logic b1, e1, saw_done;
        eb = '{8'h0E, 8'h4A, 8'hCC};
        slave_nack_at = NO_NACK;
        cs_addr = 8'h0E; rw_addr = 8'h48; input_data = 8'h55;
        en_write = 1'b1;
        @(negedge clk);
        en_write = 1'b0;
        repeat (300) @(negedge clk);
        exp_starts++;
        mon_off = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_chk++; if (scl !== 1'b1)    begin n_fail++; $display("FAIL rstmid_scl got=%b exp=1", scl); end
        n_chk++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_sda_oe got=%b exp=0", sda_oe); end
        n_chk++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        saw_done = done;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        n_chk++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done got=%b exp=0", saw_done); end
        mon_off = 1'b0;
        @(negedge clk);
        base = got.size();
        do_req(8'h0E, 8'h4A, 8'hCC, NO_NACK, lat, b1, e1);
        exp_starts++; exp_stops++;
        n_chk++; if (lat != model_lat(8'h0E, NO_NACK)) begin n_fail++; $display("FAIL rstmid_latency got=%0d exp=%0d", lat, model_lat(8'h0E, NO_NACK)); end
        n_chk++; if (got.size() - base != 3) begin n_fail++; $display("FAIL rstmid_nbytes got=%0d exp=3", got.size() - base); end
        for (int i = 0; i < 3 && base + i < got.size(); i++) begin
            n_chk++; if (got[base + i] !== eb[i]) begin n_fail++; $display("FAIL rstmid_byte%0d got=%h exp=%h", i, got[base + i], eb[i]); end
        end
    endtask

    task automatic test_back_to_back_random();
        logic [7:0] cs, rw, dat;
        logic [7:0] eb[3];
        int nk, lat, base, nb;
        logic b1, e1;
        for (int t = 0; t < 8; t++) begin
            cs  = 8'($urandom_range(0, 255));
            rw  = 8'($urandom_range(0, 255));
            dat = 8'($urandom_range(0, 255));
            nk  = $urandom_range(0, 3);
            eb  = '{cs, rw, dat};
            nb  = model_nbytes(cs, nk);
            base = got.size();
            do_req(cs, rw, dat, nk, lat, b1, e1);
            if (!cs[0]) begin exp_starts++; exp_stops++; end
            n_chk++; if (lat != model_lat(cs, nk)) begin n_fail++; $display("FAIL rand%0d_latency got=%0d exp=%0d", t, lat, model_lat(cs, nk)); end
            n_chk++; if (ack_err !== model_err(cs, nk)) begin n_fail++; $display("FAIL rand%0d_ack_err got=%b exp=%b", t, ack_err, model_err(cs, nk)); end
            n_chk++; if (b1 !== !cs[0]) begin n_fail++; $display("FAIL rand%0d_busy got=%b exp=%b", t, b1, !cs[0]); end
            if (!cs[0]) begin
                n_chk++; if (e1 !== 1'b0) begin n_fail++; $display("FAIL rand%0d_err_clear got=%b exp=0", t, e1); end
            end
            n_chk++; if (got.size() - base != nb) begin n_fail++; $display("FAIL rand%0d_nbytes got=%0d exp=%0d", t, got.size() - base, nb); end
            for (int i = 0; i < nb && base + i < got.size(); i++) begin
                n_chk++; if (got[base + i] !== eb[i]) begin n_fail++; $display("FAIL rand%0d_byte%0d got=%h exp=%h", t, i, got[base + i], eb[i]); end
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_protocol();
        n_chk++; if (viol != 0) begin n_fail++; $display("FAIL protocol_violations got=%0d exp=0", viol); end
        n_chk++; if (starts != exp_starts) begin n_fail++; $display("FAIL protocol_starts got=%0d exp=%0d", starts, exp_starts); end
        n_chk++; if (stops != exp_stops) begin n_fail++; $display("FAIL protocol_stops got=%0d exp=%0d", stops, exp_stops); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_nack_dev();
        test_ignore_busy();
        test_read_reject();
        test_reset_mid();
        test_back_to_back_random();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
